lfsr_gen: RTL and testbench

//  Parameterised Fibonacci LFSR pseudo-random bit generator with a programmable

---
 rtl/lfsr_gen_if.sv | 21 ++
 rtl/lfsr_gen.sv | 102 ++++++++++
 tb/tb_lfsr_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: run request and step/repeat settings in, burst flag and PRBS bit out.
// Pure wiring, no latency; no backpressure (the bit stream is free-running while flag_o is high).
interface lfsr_gen_if #(
    parameter int width_p = 3
);
    logic               en;
    logic [7:0]         sel_div_i;
    logic [width_p-1:0] rep_i;
    logic               flag_o;
    logic               sig_o;

    modport master (
        output en, sel_div_i, rep_i,
        input  flag_o, sig_o
    );

    modport slave (
        input  en, sel_div_i, rep_i,
        output flag_o, sig_o
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR PRBS burst generator; first bit one clock after en, each bit held sel_div_i+1 clocks.
// No backpressure: the stream runs open-loop, en=0 aborts to idle on the next clock.
module lfsr_gen #(
    parameter int                 width_p = 3,
    parameter logic [width_p-1:0] mask_p  = 3'b110
) (
    input  logic        clk,
    input  logic        srst_n,
    lfsr_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [width_p-1:0] SEED = '1;
    localparam logic [width_p-1:0] ONE  = {{(width_p-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [width_p-1:0] lfsr, lfsr_nxt, lfsr_step;
    logic [7:0]         div_cnt, div_nxt, n_lat, n_nxt;
    logic [width_p-1:0] rep_cnt, rep_nxt, rep_lat, repl_nxt, rep_inc;
    logic               fb;

    assign fb        = ^(lfsr & mask_p);
    assign lfsr_step = {lfsr[width_p-2:0], fb};
    assign rep_inc   = rep_cnt + ONE;

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        div_nxt   = div_cnt;
        rep_nxt   = rep_cnt;
        n_nxt     = n_lat;
        repl_nxt  = rep_lat;
        case (state)
            IDLE: begin
                lfsr_nxt = SEED;
                div_nxt  = '0;
                rep_nxt  = '0;
                if (bus.en) begin
                    state_nxt = RUN;
                    n_nxt     = bus.sel_div_i;
                    repl_nxt  = bus.rep_i;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_nxt = IDLE;
                    lfsr_nxt  = SEED;
                    div_nxt   = '0;
                    rep_nxt   = '0;
                end else if (div_cnt == n_lat) begin
                    div_nxt  = '0;
                    lfsr_nxt = lfsr_step;
                    // Returning to SEED closes one full period; rep_lat==0 means run forever.
                    if (lfsr_step == SEED) begin
                        rep_nxt = rep_inc;
                        if ((rep_lat != '0) && (rep_inc == rep_lat)) begin
                            state_nxt = DONE;
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            DONE: begin
                lfsr_nxt = SEED;
                div_nxt  = '0;
                rep_nxt  = '0;
                if (!bus.en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                lfsr_nxt  = SEED;
                div_nxt   = '0;
                rep_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state   <= IDLE;
            lfsr    <= SEED;
            div_cnt <= '0;
            rep_cnt <= '0;
            n_lat   <= '0;
            rep_lat <= '0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            div_cnt <= div_nxt;
            rep_cnt <= rep_nxt;
            n_lat   <= n_nxt;
            rep_lat <= repl_nxt;
        end
    end

    // Outputs decode registered state only, so nothing combinational reaches them from inputs.
    assign bus.flag_o = (state == RUN);
    assign bus.sig_o  = lfsr[width_p-1] & (state == RUN);
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen (width 3, mask 110): burst length, bit pattern, abort, reset and endless mode.
module tb_lfsr_gen;
    logic clk;
    logic srst_n;
    int   total;
    int   passed;
    logic [6:0] pat;

    lfsr_gen_if #(.width_p(3)) bus ();

    lfsr_gen #(.width_p(3), .mask_p(3'b110)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples at negedge until the burst ends or limit high cycles are seen.
    task automatic run_burst(input int n, input int limit, output int lat, output int len,
                             output int mism, output logic [20:0] seq);
        int idx;
        lat  = 0;
        len  = 0;
        mism = 0;
        seq  = '0;
        for (int c = 0; c < limit + 50; c++) begin
            @(negedge clk);
            if (bus.flag_o) begin
                if (len == 0) lat = c + 1;
                len++;
                idx = ((len - 1) / (n + 1)) % 7;
                if (bus.sig_o !== pat[6-idx]) mism++;
                if (((len - 1) % (n + 1)) == 0) seq = {seq[19:0], bus.sig_o};
                if (len >= limit) break;
            end else if (len > 0) begin
                break;
            end
        end
    endtask

    task automatic start(input logic [7:0] n, input logic [2:0] rep);
        @(negedge clk);
        bus.sel_div_i = n;
        bus.rep_i     = rep;
        bus.en        = 1'b1;
    endtask

    task automatic stop_run();
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        srst_n        = 1'b0;
        bus.en        = 1'b1;
        bus.sel_div_i = 8'd0;
        bus.rep_i     = 3'd0;
        #1;
        total++; if (bus.flag_o !== 1'b0) $display("FAIL reset_flag got=%b exp=0", bus.flag_o); else passed++;
        total++; if (bus.sig_o !== 1'b0) $display("FAIL reset_sig got=%b exp=0", bus.sig_o); else passed++;
        bus.en = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst_div5_rep3();
        int lat, len, mism;
        logic [20:0] seq;
        int hi;
        start(8'd5, 3'd3);
        run_burst(5, 200, lat, len, mism, seq);
        total++; if (lat !== 1) $display("FAIL b1_latency got=%0d exp=1", lat); else passed++;
        total++; if (len !== 126) $display("FAIL b1_length got=%0d exp=126", len); else passed++;
        total++; if (mism !== 0) $display("FAIL b1_model_mismatches got=%0d exp=0", mism); else passed++;
        total++; if (seq !== 21'b111001011100101110010) $display("FAIL b1_sampled_bits got=%b exp=111001011100101110010", seq); else passed++;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.flag_o !== 1'b0 || bus.sig_o !== 1'b0) hi++;
        end
        total++; if (hi !== 0) $display("FAIL b1_done_hold got=%0d exp=0 active cycles", hi); else passed++;
    endtask

    task automatic test_div0_rep1();
        int lat, len, mism;
        logic [20:0] seq;
        stop_run();
        start(8'd0, 3'd1);
        run_burst(0, 50, lat, len, mism, seq);
        total++; if (lat !== 1) $display("FAIL r1_latency got=%0d exp=1", lat); else passed++;
        total++; if (len !== 7) $display("FAIL r1_length got=%0d exp=7", len); else passed++;
        total++; if (mism !== 0) $display("FAIL r1_model_mismatches got=%0d exp=0", mism); else passed++;
        total++; if (seq[6:0] !== 7'b1110010) $display("FAIL r1_bits got=%b exp=1110010", seq[6:0]); else passed++;
    endtask

    task automatic test_endless();
        int lat, len, mism;
        logic [20:0] seq;
        stop_run();
        start(8'd0, 3'd0);
        run_burst(0, 105, lat, len, mism, seq);
        total++; if (lat !== 1) $display("FAIL endless_latency got=%0d exp=1", lat); else passed++;
        total++; if (len !== 105) $display("FAIL endless_length got=%0d exp=105", len); else passed++;
        total++; if (mism !== 0) $display("FAIL endless_mismatches got=%0d exp=0", mism); else passed++;
        total++; if (seq !== 21'b111001011100101110010) $display("FAIL endless_tail got=%b exp=111001011100101110010", seq); else passed++;
        bus.en = 1'b0;
        @(negedge clk);
        total++; if (bus.flag_o !== 1'b0) $display("FAIL endless_drop_flag got=%b exp=0", bus.flag_o); else passed++;
        total++; if (bus.sig_o !== 1'b0) $display("FAIL endless_drop_sig got=%b exp=0", bus.sig_o); else passed++;
        bus.en = 1'b1;
        run_burst(0, 14, lat, len, mism, seq);
        total++; if (lat !== 1) $display("FAIL restart_latency got=%0d exp=1", lat); else passed++;
        total++; if (len !== 14) $display("FAIL restart_length got=%0d exp=14", len); else passed++;
        total++; if (seq[13:0] !== 14'b11100101110010) $display("FAIL restart_bits got=%b exp=11100101110010", seq[13:0]); else passed++;
    endtask

    task automatic test_abort();
        int lat, len, mism;
        logic [20:0] seq;
        stop_run();
        start(8'd1, 3'd2);
        fork
            begin
                repeat (5) @(negedge clk);
                bus.rep_i     = 3'd0;
                bus.sel_div_i = 8'd7;
            end
        join_none
        run_burst(1, 100, lat, len, mism, seq);
        total++; if (len !== 28) $display("FAIL midchange_length got=%0d exp=28", len); else passed++;
        total++; if (mism !== 0) $display("FAIL midchange_mismatches got=%0d exp=0", mism); else passed++;
        stop_run();
        start(8'd1, 3'd2);
        repeat (10) @(negedge clk);
        total++; if (bus.flag_o !== 1'b1) $display("FAIL prereset_flag got=%b exp=1", bus.flag_o); else passed++;
        srst_n = 1'b0;
        #1;
        total++; if (bus.flag_o !== 1'b0) $display("FAIL midreset_flag got=%b exp=0", bus.flag_o); else passed++;
        total++; if (bus.sig_o !== 1'b0) $display("FAIL midreset_sig got=%b exp=0", bus.sig_o); else passed++;
        @(negedge clk);
        srst_n = 1'b1;
        run_burst(1, 100, lat, len, mism, seq);
        total++; if (lat !== 1) $display("FAIL fresh_latency got=%0d exp=1", lat); else passed++;
        total++; if (len !== 28) $display("FAIL fresh_length got=%0d exp=28", len); else passed++;
        total++; if (mism !== 0) $display("FAIL fresh_mismatches got=%0d exp=0", mism); else passed++;
        total++; if (seq[13:0] !== 14'b11100101110010) $display("FAIL fresh_bits got=%b exp=11100101110010", seq[13:0]); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        pat    = 7'b1110010;
        test_reset();
        test_burst_div5_rep3();
        test_div0_rep1();
        test_endless();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
